pht_round_mix: RTL and testbench

//  - Twofish round back-end, directly downstream of the two mds instances that form g(R0) and g(ROL(R1,8)).
//  - Takes T0/T1 plus R2/R3 and performs the pseudo-Hadamard transform and round-subkey addition.
//  - Applies the 1-bit rotate/XOR into R2/R3 and returns the new word pair to the round controller.
//  - 2-stage valid/ready pipeline; round subkeys come from the keystore over a fixed-latency request port.

---
 rtl/pht_round_mix_pkg.sv | 21 ++
 rtl/pht_round_mix_if.sv | 41 ++++
 rtl/pht_round_mix_core.sv | 24 ++
 rtl/pht_round_mix.sv | 153 +++++++++++++++
 tb/tb_pht_round_mix.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pht_round_mix_pkg.sv
// Shared Twofish round types, defaults and rotate helpers.
// Purpose: word/round types and constants. Latency: n/a. Backpressure: n/a.
package twofish_pkg;

    localparam int DEF_NUM_ROUNDS = 16;
    localparam int DEF_RND_W      = $clog2(DEF_NUM_ROUNDS);
    localparam int SK_ROUND_BASE  = 8;

    typedef logic [31:0]          word_t;
    typedef logic [DEF_RND_W-1:0] round_t;

    // A zero amount shifts the complementary half by 32, which yields 0, so n=0 is safe.
    function automatic word_t rol32(input word_t x, input logic [4:0] n);
        rol32 = (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic word_t ror32(input word_t x, input logic [4:0] n);
        ror32 = (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/pht_round_mix_if.sv
// Round-mix bundle: input beat, keystore request/response and result beat.
// Purpose: signal grouping only. Latency: n/a. Backpressure: valid/ready on in_* and out_*.
interface pht_round_mix_if #(
    parameter int RND_W = 4
);
    import twofish_pkg::*;

    logic             in_valid;
    logic             in_ready;
    word_t            in_t0;
    word_t            in_t1;
    word_t            in_r2;
    word_t            in_r3;
    logic [RND_W-1:0] in_round;
    logic             in_dec;

    logic             sk_req;
    logic [5:0]       sk_idx;
    word_t            sk_k0;
    word_t            sk_k1;

    logic             out_valid;
    logic             out_ready;
    word_t            out_r2;
    word_t            out_r3;
    logic             out_last;

    // Environment side: round controller, mds outputs and keystore.
    modport master (
        output in_valid, in_t0, in_t1, in_r2, in_r3, in_round, in_dec,
        output sk_k0, sk_k1, out_ready,
        input  in_ready, sk_req, sk_idx, out_valid, out_r2, out_r3, out_last
    );

    modport slave (
        input  in_valid, in_t0, in_t1, in_r2, in_r3, in_round, in_dec,
        input  sk_k0, sk_k1, out_ready,
        output in_ready, sk_req, sk_idx, out_valid, out_r2, out_r3, out_last
    );

endinterface

// File: rtl/pht_round_mix_core.sv
// Pseudo-Hadamard transform and round-subkey addition, all mod 2^32.
// Purpose: (t0,t1)->(p0,p1) and (p0,p1,k0,k1)->(f0,f1). Latency: 0, combinational. Backpressure: none.
module pht_core
    import twofish_pkg::*;
(
    input  word_t t0,
    input  word_t t1,
    input  word_t p0_q,
    input  word_t p1_q,
    input  word_t k0,
    input  word_t k1,
    output word_t p0,
    output word_t p1,
    output word_t f0,
    output word_t f1
);

    // The transform is split so the caller can register p0/p1 before keys arrive.
    assign p0 = t0 + t1;
    assign p1 = t0 + (t1 << 1);
    assign f0 = p0_q + k0;
    assign f1 = p1_q + k1;

endmodule

// File: rtl/pht_round_mix.sv
// Twofish round back-end: PHT, subkey add and 1-bit rotate/XOR into R2/R3. Macro: TWOFISH_DECRYPT_EN.
// Purpose: new R2/R3 per round. Latency: 2 cycles accept-to-out_valid, 1 beat/cycle.
// Backpressure: out_ready low holds S2, S1 then fills and in_ready drops.
module pht_round_mix
    import twofish_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int RND_W      = $clog2(NUM_ROUNDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    pht_round_mix_if.slave   bus
);

    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS - 1);

    // Stage 1 state
    logic             s1_full;
    logic             key_pend;
    logic             key_ok;
    word_t            s1_p0;
    word_t            s1_p1;
    word_t            s1_r2;
    word_t            s1_r3;
    word_t            s1_k0;
    word_t            s1_k1;
    logic [RND_W-1:0] s1_round;
`ifdef TWOFISH_DECRYPT_EN
    logic             s1_dec;
`endif

    // Stage 2 state
    logic             s2_full;
    word_t            s2_r2;
    word_t            s2_r3;
    logic             s2_last;

    logic             in_ready;
    logic             accept;
    logic             key_live;
    logic             s1_adv;
    logic [5:0]       sk_idx_calc;
    word_t            k0_use;
    word_t            k1_use;
    word_t            p0_nxt;
    word_t            p1_nxt;
    word_t            f0;
    word_t            f1;
    word_t            r2_nxt;
    word_t            r3_nxt;

    // Keys are usable either straight off the keystore (cycle after accept) or from the held copy.
    assign key_live = key_pend | key_ok;
    assign k0_use   = key_pend ? bus.sk_k0 : s1_k0;
    assign k1_use   = key_pend ? bus.sk_k1 : s1_k1;

    assign s1_adv   = s1_full && key_live && (!s2_full || bus.out_ready);
    assign in_ready = rst_n && (!s1_full || s1_adv);
    assign accept   = bus.in_valid && in_ready;

    // Out-of-range rounds simply wrap within the 6-bit keystore index.
    assign sk_idx_calc = 6'({bus.in_round, 1'b0}) + 6'(SK_ROUND_BASE);

    assign bus.in_ready  = in_ready;
    assign bus.sk_req    = accept;
    assign bus.sk_idx    = accept ? sk_idx_calc : 6'd0;
    assign bus.out_valid = s2_full;
    assign bus.out_r2    = s2_r2;
    assign bus.out_r3    = s2_r3;
    assign bus.out_last  = s2_last;

    pht_core u_pht (
        .t0   (bus.in_t0),
        .t1   (bus.in_t1),
        .p0_q (s1_p0),
        .p1_q (s1_p1),
        .k0   (k0_use),
        .k1   (k1_use),
        .p0   (p0_nxt),
        .p1   (p1_nxt),
        .f0   (f0),
        .f1   (f1)
    );

    always_comb begin
        r2_nxt = ror32(s1_r2 ^ f0, 5'd1);
        r3_nxt = rol32(s1_r3, 5'd1) ^ f1;
`ifdef TWOFISH_DECRYPT_EN
        if (s1_dec) begin
            r2_nxt = rol32(s1_r2, 5'd1) ^ f0;
            r3_nxt = ror32(s1_r3 ^ f1, 5'd1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full  <= 1'b0;
            key_pend <= 1'b0;
            key_ok   <= 1'b0;
            s1_p0    <= '0;
            s1_p1    <= '0;
            s1_r2    <= '0;
            s1_r3    <= '0;
            s1_k0    <= '0;
            s1_k1    <= '0;
            s1_round <= '0;
`ifdef TWOFISH_DECRYPT_EN
            s1_dec   <= 1'b0;
`endif
        end else begin
            key_pend <= accept;
            // Capture the one-shot keystore response; later assignments below override key_ok.
            if (key_pend) begin
                s1_k0  <= bus.sk_k0;
                s1_k1  <= bus.sk_k1;
                key_ok <= 1'b1;
            end
            if (accept) begin
                s1_full  <= 1'b1;
                key_ok   <= 1'b0;
                s1_p0    <= p0_nxt;
                s1_p1    <= p1_nxt;
                s1_r2    <= bus.in_r2;
                s1_r3    <= bus.in_r3;
                s1_round <= bus.in_round;
`ifdef TWOFISH_DECRYPT_EN
                s1_dec   <= bus.in_dec;
`endif
            end else if (s1_adv) begin
                s1_full <= 1'b0;
                key_ok  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_full <= 1'b0;
            s2_r2   <= '0;
            s2_r3   <= '0;
            s2_last <= 1'b0;
        end else if (s1_adv) begin
            s2_full <= 1'b1;
            s2_r2   <= r2_nxt;
            s2_r3   <= r3_nxt;
            s2_last <= (s1_round == LAST_ROUND);
        end else if (bus.out_ready) begin
            s2_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pht_round_mix.sv
// Randomized bench for pht_round_mix against an arithmetic round model and keystore model.
module tb_pht_round_mix;
    import twofish_pkg::*;

    typedef struct {
        word_t r2;
        word_t r3;
        logic  last;
        int    acc;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    always #5 clk = ~clk;

    pht_round_mix_if #(.RND_W(DEF_RND_W)) bus ();

    pht_round_mix #(.NUM_ROUNDS(DEF_NUM_ROUNDS), .RND_W(DEF_RND_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    word_t ks [64];
    exp_t  q [$];
    logic  ks_pend = 1'b0;
    int    ks_idx  = 0;
    logic  lat_chk = 1'b0;
    logic  prev_stall = 1'b0;
    word_t prev_r2, prev_r3;
    logic  prev_last;
    word_t last_r2 = '0;
    word_t last_r3 = '0;
    logic  last_last = 1'b0;
    int    bp_drops = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic word_t rot_r1(input word_t x);
        return (x >> 1) | (x << 31);
    endfunction

    function automatic word_t rot_l1(input word_t x);
        return (x << 1) | (x >> 31);
    endfunction

    // One Twofish round half, straight from the arithmetic definition.
    function automatic exp_t model(input word_t t0, t1, r2, r3, input int rnd, input logic dec);
        exp_t  m;
        int    i0;
        word_t f0, f1;
        i0 = (2 * rnd + SK_ROUND_BASE) % 64;
        f0 = t0 + t1 + ks[i0];
        f1 = t0 + 2 * t1 + ks[(i0 + 1) % 64];
`ifdef TWOFISH_DECRYPT_EN
        if (dec) begin
            m.r2 = rot_l1(r2) ^ f0;
            m.r3 = rot_r1(r3 ^ f1);
        end else begin
            m.r2 = rot_r1(r2 ^ f0);
            m.r3 = rot_l1(r3) ^ f1;
        end
`else
        m.r2 = rot_r1(r2 ^ f0);
        m.r3 = rot_l1(r3) ^ f1;
        if (dec) m.last = 1'b0;
`endif
        m.last = (rnd == DEF_NUM_ROUNDS - 1);
        m.acc  = cyc;
        return m;
    endfunction

    task automatic step(input logic v, input word_t t0, t1, r2, r3, input int rnd,
                        input logic dec, input logic ordy, output logic acc);
        exp_t e;
        logic exp_rdy;
        @(negedge clk);
        if (ks_pend) begin
            bus.sk_k0 = ks[ks_idx];
            bus.sk_k1 = ks[(ks_idx + 1) % 64];
        end else begin
            bus.sk_k0 = $urandom;
            bus.sk_k1 = $urandom;
        end
        bus.in_valid  = v;
        bus.in_t0     = t0;
        bus.in_t1     = t1;
        bus.in_r2     = r2;
        bus.in_r3     = r3;
        bus.in_round  = round_t'(rnd);
        bus.in_dec    = dec;
        bus.out_ready = ordy;
        #1;
        cyc++;
        exp_rdy = !(q.size() >= 2 && !ordy);
        check("in_ready", bus.in_ready, exp_rdy);
        if (!bus.in_ready) bp_drops++;
        acc = v && bus.in_ready;
        check("sk_req", bus.sk_req, acc);
        if (acc) check("sk_idx", bus.sk_idx, (2 * rnd + SK_ROUND_BASE) % 64);
        if (prev_stall) begin
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_r2", bus.out_r2, prev_r2);
            check("hold_r3", bus.out_r3, prev_r3);
            check("hold_last", bus.out_last, prev_last);
        end
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", bus.out_valid, 1'b0);
            end else begin
                e = q[0];
                check("out_r2", bus.out_r2, e.r2);
                check("out_r3", bus.out_r3, e.r3);
                check("out_last", bus.out_last, e.last);
                if (ordy) begin
                    if (lat_chk) check("latency", cyc - e.acc, 2);
                    last_r2   = bus.out_r2;
                    last_r3   = bus.out_r3;
                    last_last = bus.out_last;
                    void'(q.pop_front());
                end
            end
        end
        prev_stall = bus.out_valid && !ordy;
        prev_r2    = bus.out_r2;
        prev_r3    = bus.out_r3;
        prev_last  = bus.out_last;
        if (acc) q.push_back(model(t0, t1, r2, r3, rnd, dec));
        ks_pend = acc;
        ks_idx  = (2 * rnd + SK_ROUND_BASE) % 64;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, 0, 1'b0, 1'b1, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic  acc;
        logic  have;
        int    sent;
        word_t c0, c1, c2, c3;
        int    crnd;
        logic  cdec;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_t0 = '0; bus.in_t1 = '0; bus.in_r2 = '0; bus.in_r3 = '0;
        bus.in_round = '0; bus.in_dec = 1'b0; bus.out_ready = 1'b0;
        bus.sk_k0 = '0; bus.sk_k1 = '0;
        foreach (ks[i]) ks[i] = $urandom;
        #2;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_sk_req", bus.sk_req, 1'b0);
        check("rst_sk_idx", bus.sk_idx, 6'd0);
        check("rst_out_r2", bus.out_r2, 32'd0);
        check("rst_out_r3", bus.out_r3, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic encrypt beat and two-cycle latency
        lat_chk = 1'b1;
        ks[8] = 32'd0; ks[9] = 32'd0;
        step(1'b1, 32'd0, 32'd1, 32'd0, 32'd0, 0, 1'b0, 1'b1, acc);
        check("basic_acc", acc, 1'b1);
        idle(3);
        check("basic_r2", last_r2, 32'h8000_0000);
        check("basic_r3", last_r3, 32'h0000_0002);

        // Mod 2^32 wrap in PHT and key add
        ks[8] = 32'd1; ks[9] = 32'd0;
        step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 1'b0, 1'b1, acc);
        idle(3);
        check("wrap_r2", last_r2, 32'hFFFF_FFFF);
        check("wrap_r3", last_r3, 32'hFFFF_FFFD);

        // Back-to-back rounds 0..15
        foreach (ks[i]) ks[i] = $urandom;
        for (int r = 0; r < DEF_NUM_ROUNDS; r++) begin
            step(1'b1, $urandom, $urandom, $urandom, $urandom, r, 1'(($urandom)), 1'b1, acc);
            check("stream_acc", acc, 1'b1);
        end
        idle(3);
        check("stream_last", last_last, 1'b1);
        lat_chk = 1'b0;

        // Five-cycle output stall mid-stream
        bp_drops = 0;
        sent = 0;
        c0 = $urandom; c1 = $urandom; c2 = $urandom; c3 = $urandom; crnd = $urandom_range(0, 15);
        for (int k = 0; k < 20; k++) begin
            step(sent < 8, c0, c1, c2, c3, crnd, 1'b0, !(k >= 3 && k < 8), acc);
            if (acc) begin
                sent++;
                c0 = $urandom; c1 = $urandom; c2 = $urandom; c3 = $urandom; crnd = $urandom_range(0, 15);
            end
        end
        idle(3);
        check("bp_in_ready_dropped", (bp_drops > 0), 1'b1);
        check("bp_all_sent", sent, 8);
        check("bp_drained", q.size(), 0);

`ifdef TWOFISH_DECRYPT_EN
        ks[8] = 32'd0; ks[9] = 32'd0;
        step(1'b1, 32'd0, 32'd0, 32'd1, 32'd1, 0, 1'b1, 1'b1, acc);
        idle(3);
        check("dec_r2", last_r2, 32'h0000_0002);
        check("dec_r3", last_r3, 32'h8000_0000);
`endif

        // Random traffic with random backpressure
        foreach (ks[i]) ks[i] = $urandom;
        have = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!have && ($urandom % 4) != 0) begin
                have = 1'b1;
                c0 = $urandom; c1 = $urandom; c2 = $urandom; c3 = $urandom;
                crnd = $urandom_range(0, 15); cdec = 1'(($urandom));
            end
            step(have, c0, c1, c2, c3, crnd, cdec, ($urandom % 4) != 0, acc);
            if (acc) have = 1'b0;
        end
        idle(3);
        check("rand_drained", q.size(), 0);

        // Reset one cycle after accept: the beat and its late key response vanish
        step(1'b1, $urandom, $urandom, $urandom, $urandom, 3, 1'b0, 1'b1, acc);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.sk_k0 = ks[ks_idx];
        bus.sk_k1 = ks[(ks_idx + 1) % 64];
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_sk_req", bus.sk_req, 1'b0);
        check("midrst_out_r2", bus.out_r2, 32'd0);
        q.delete();
        ks_pend = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);

        check("final_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
